// File: rtl/serial_adder_pkg.sv
// Shared definitions for multi-cycle ALU blocks: FSM state encoding and
// the slice-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Bits needed to count width/2 two-bit slices (never narrower than 1).
  function automatic int unsigned slice_cnt_w(input int unsigned width);
    if (width < 4) return 1;
    return $clog2(width / 2);
  endfunction

endpackage

// File: rtl/twobit_adder.sv
// Two-bit ripple slice: sum and carry of a + b + cin.
module twobit_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum_c,
  output logic       cout_c
);

  assign {cout_c, sum_c} = 3'(a) + 3'(b) + 3'(cin);

endmodule

// File: rtl/serial_adder.sv
// Serial add/subtract: processes two bits per cycle through one twobit_adder,
// delivering result, carry, signed overflow and zero after WIDTH/2 cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CNT_W      = slice_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WIDTH / 2 - 1);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       slice_sum_c;
  logic             slice_cout_c;

  twobit_adder u_slice (
    .a      (op_a_q[1:0]),
    .b      (op_b_q[1:0]),
    .cin    (carry_q),
    .sum_c  (slice_sum_c),
    .cout_c (slice_cout_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    msb_a_d  = msb_a_q;
    msb_b_d  = msb_b_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          op_a_d   = a;
          op_b_d   = sub ? ~b : b;
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          c_out_d  = 1'b0;
          ovf_d    = 1'b0;
          msb_a_d  = a[WIDTH-1];
          msb_b_d  = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[{cnt_q, 1'b0} +: 2] = slice_sum_c;
        carry_d = slice_cout_c;
        op_a_d  = op_a_q >> 2;
        op_b_d  = op_b_q >> 2;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
          c_out_d = slice_cout_c;
          // Same-sign operands whose result sign flips
          ovf_d   = (msb_a_q == msb_b_q) && (slice_sum_c[1] != msb_a_q);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      msb_a_q  <= 1'b0;
      msb_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      msb_a_q  <= msb_a_d;
      msb_b_q  <= msb_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
  assign zero     = ~|result_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against a wide-integer arithmetic model.
module tb_serial_adder;

  localparam int unsigned W   = 32;
  localparam int          LAT = 17;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b, result;
  logic         c_out, overflow, zero, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns {overflow, carry/no-borrow, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    longint              ux, uy, u, sx, sy, sr;
    logic signed [W-1:0] xs, ys, trunc;
    logic                c, ov;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    xs = x;
    ys = y;
    sx = longint'(xs);
    sy = longint'(ys);
    u  = s ? (ux - uy) : (ux + uy);
    c  = s ? (ux >= uy) : (ux + uy > 64'h0000_0000_FFFF_FFFF);
    sr = s ? (sx - sy) : (sx + sy);
    trunc = sr[W-1:0];
    ov = (longint'(trunc) != sr);
    return {ov, c, u[W-1:0]};
  endfunction

  // Launches one operation and waits (bounded) for done; lat counts cycles since start.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output int lat);
    a = x; b = y; sub = s; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done); end
    checks++; if (result !== '0 || c_out !== 1'b0 || overflow !== 1'b0) begin errors++;
      $display("FAIL reset_data: result=%h c_out=%b ovf=%b required 0", result, c_out, overflow); end
    checks++; if (zero !== 1'b1) begin errors++;
      $display("FAIL reset_zero: zero=%b required 1", zero); end
    repeat (2) tick;
    #3 rst = 1'b0;
    repeat (2) tick;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL idle_hold: busy=%b done=%b required 0 0", busy, done); end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[4], tb[4], tr[4];
    logic         ts[4], tc[4], tv[4];
    int lat;
    ta = '{32'd5, 32'hFFFF_FFFF, 32'd3, 32'h7FFF_FFFF};
    tb = '{32'd5, 32'd1, 32'd5, 32'd1};
    ts = '{1'b0, 1'b0, 1'b1, 1'b0};
    tr = '{32'h0000_000A, 32'h0, 32'hFFFF_FFFE, 32'h8000_0000};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0};
    tv = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], ts[i], lat);
      checks++; if (lat != LAT) begin errors++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, LAT); end
      checks++; if (result !== tr[i]) begin errors++;
        $display("FAIL dir%0d_result: got %h required %h", i, result, tr[i]); end
      checks++; if (c_out !== tc[i] || overflow !== tv[i]) begin errors++;
        $display("FAIL dir%0d_flags: c_out=%b ovf=%b required %b %b", i, c_out, overflow, tc[i], tv[i]); end
      checks++; if (zero !== (tr[i] == '0)) begin errors++;
        $display("FAIL dir%0d_zero: got %b required %b", i, zero, (tr[i] == '0)); end
      tick;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL dir%0d_pulse: done=%b busy=%b required 0 0", i, done, busy); end
      repeat (3) tick;
      checks++; if (result !== tr[i] || c_out !== tc[i] || overflow !== tv[i]) begin errors++;
        $display("FAIL dir%0d_hold: result=%h required %h", i, result, tr[i]); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic         s;
    logic [W+1:0] e;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      s = 1'($urandom_range(0, 1));
      e = model(x, y, s);
      do_op(x, y, s, lat);
      checks++; if (lat != LAT) begin errors++;
        $display("FAIL rnd%0d_latency: got %0d required %0d", i, lat, LAT); end
      checks++; if (result !== e[W-1:0] || zero !== (e[W-1:0] == '0)) begin errors++;
        $display("FAIL rnd%0d_result: %h %s %h got %h zero=%b required %h", i, x, s ? "-" : "+", y,
                 result, zero, e[W-1:0]); end
      checks++; if (c_out !== e[W] || overflow !== e[W+1]) begin errors++;
        $display("FAIL rnd%0d_flags: c_out=%b ovf=%b required %b %b", i, c_out, overflow, e[W], e[W+1]); end
      tick;
    end
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] x, y, r;
    logic         s, c;
    logic [W+1:0] e;
    int lat, ndone, dlat;
    x = $urandom; y = $urandom; s = 1'b0;
    e = model(x, y, s);
    a = x; b = y; sub = s; start = 1'b1;
    tick;
    lat = 1; ndone = 0; dlat = -1; r = '0; c = 1'b0;
    while (lat < 30) begin
      if (lat == 4 || lat == 10) begin
        start = 1'b1; a = $urandom; b = $urandom; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (lat == 4) begin
        checks++; if (busy !== 1'b1) begin errors++;
          $display("FAIL ign_busy: got %b required 1", busy); end
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin dlat = lat; r = result; c = c_out; end
      end
      tick;
      lat++;
    end
    start = 1'b0;
    checks++; if (ndone != 1 || dlat != LAT) begin errors++;
      $display("FAIL ign_done: pulses=%0d at %0d required 1 at %0d", ndone, dlat, LAT); end
    checks++; if (r !== e[W-1:0] || c !== e[W]) begin errors++;
      $display("FAIL ign_result: got %h c=%b required %h c=%b", r, c, e[W-1:0], e[W]); end
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] x, y;
    logic [W+1:0] e;
    int lat, ndone;
    a = $urandom | 32'h1; b = $urandom; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL abort_ctrl: busy=%b done=%b required 0 0", busy, done); end
    checks++; if (result !== '0 || zero !== 1'b1) begin errors++;
      $display("FAIL abort_result: result=%h zero=%b required 0 1", result, zero); end
    ndone = 0;
    repeat (3) begin tick; if (done === 1'b1) ndone++; end
    x = $urandom; y = $urandom;
    e = model(x, y, 1'b1);
    #2 rst = 1'b0;
    do_op(x, y, 1'b1, lat);
    checks++; if (ndone != 0) begin errors++;
      $display("FAIL abort_nodone: pulses=%0d required 0", ndone); end
    checks++; if (lat != LAT || result !== e[W-1:0] || c_out !== e[W] || overflow !== e[W+1]) begin errors++;
      $display("FAIL abort_restart: lat=%0d result=%h required lat=%0d result=%h", lat, result, LAT, e[W-1:0]); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] x1, y1, x2, y2, r1, r2;
    logic         s2, bz;
    logic [W+1:0] e1, e2;
    int lat, d1, d2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom; s2 = 1'b1;
    e1 = model(x1, y1, 1'b0);
    e2 = model(x2, y2, s2);
    a = x1; b = y1; sub = 1'b0; start = 1'b1;
    tick;
    a = x2; b = y2; sub = s2;
    lat = 1; d1 = -1; d2 = -1; r1 = '0; r2 = '0; bz = 1'b0;
    while (lat < 45) begin
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = lat; r1 = result; end
        else if (d2 < 0) begin d2 = lat; r2 = result; end
      end
      if (d1 >= 0 && lat == d1 + 1) begin bz = busy; start = 1'b0; end
      tick;
      lat++;
    end
    start = 1'b0;
    checks++; if (d1 != LAT || d2 != 2 * LAT) begin errors++;
      $display("FAIL b2b_timing: done at %0d,%0d required %0d,%0d", d1, d2, LAT, 2 * LAT); end
    checks++; if (bz !== 1'b1) begin errors++;
      $display("FAIL b2b_busy: got %b required 1", bz); end
    checks++; if (r1 !== e1[W-1:0]) begin errors++;
      $display("FAIL b2b_first: got %h required %h", r1, e1[W-1:0]); end
    checks++; if (r2 !== e2[W-1:0] || c_out !== e2[W] || overflow !== e2[W+1]) begin errors++;
      $display("FAIL b2b_second: got %h c=%b v=%b required %h c=%b v=%b", r2, c_out, overflow,
               e2[W-1:0], e2[W], e2[W+1]); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    test_reset;
    test_directed;
    test_random;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
